seven_seg_scan_driver: RTL and testbench

//   Multi-digit, time-multiplexed seven-segment display driver for the game board.

---
 rtl/seven_seg_scan_driver.sv | 193 +++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 7-segment driver: latched nibbles, hex/game decode,
// guard-banded digit scan, leading-zero blanking, blink and decimal points.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   load              capture value/mode/dp_in into the shadow registers
//   value [4*DIGITS]  nibble k drives digit k (digit 0 = rightmost)
//   mode              0 = hex, 1 = game-code decode
//   dp_in [DIGITS]    decimal point per digit, active-high
//   blank_lz          leading-zero blanking enable (live)
//   blink_mask        digits that blink (live)
//   seg, dp, an       active-low display pins, registered
//   frame_tick        1-cycle pulse when the digit index wraps to 0
module seven_seg_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  mode,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = $clog2(BLINK_FRAMES) + 1;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         frame_cnt;
  logic                  blink_phase;
  logic [4*DIGITS-1:0]   val_sh;
  logic                  mode_sh;
  logic [DIGITS-1:0]     dp_sh;

  logic                  presc_wrap;
  logic                  idx_wrap;
  logic                  frame_wrap;
  logic                  blink_wrap;
  logic [DIGITS-1:0]     lzb;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_lzb;
  logic                  cur_blink;
  logic                  lit;
  logic                  guard_done;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [DIGITS-1:0]     an_d;

  function automatic logic [6:0] glyph(
    input logic [3:0] n
  );
    case (n)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Game codes: 0 -> F, 1..10 -> digits 0..9,
  // 11..15 land on the hex letters b..F unchanged.
  function automatic logic [3:0] sym(
    input logic [3:0] n,
    input logic       gm
  );
    sym = n;
    if (gm) begin
      unique case (1'b1)
        (n == 4'd0):                sym = 4'hF;
        (n >= 4'd1 && n <= 4'd10):  sym = n - 4'd1;
        default:                    sym = n;
      endcase
    end
  endfunction

  function automatic logic is_zero(
    input logic [3:0] n,
    input logic       gm
  );
    is_zero = gm ? (n == 4'd1) : (n == 4'd0);
  endfunction

  assign presc_wrap = (presc == PW'(SCAN_DIV - 1));
  assign idx_wrap   = (idx == IW'(DIGITS - 1));
  assign frame_wrap = presc_wrap & idx_wrap;
  assign blink_wrap = (frame_cnt == FW'(BLINK_FRAMES - 1));
  assign guard_done = (presc >= PW'(GUARD));

  // Blank from the top digit down while it reads as zero.
  always_comb begin
    logic run;
    lzb = '0;
    run = blank_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (run && is_zero(val_sh[4*i +: 4], mode_sh))
        lzb[i] = 1'b1;
      else
        run = 1'b0;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_lzb   = 1'b0;
    cur_blink = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_nib   = val_sh[4*i +: 4];
        cur_dp    = dp_sh[i];
        cur_lzb   = lzb[i];
        cur_blink = blink_mask[i];
      end
    end
  end

  // Segments are driven through the guard so they settle
  // before the anode turns on.
  always_comb begin
    lit   = ~cur_lzb & ~(blink_phase & cur_blink);
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = '1;
    if (lit) begin
      seg_d = glyph(sym(cur_nib, mode_sh));
      dp_d  = ~cur_dp;
      if (guard_done)
        an_d = ~(DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      val_sh      <= '0;
      mode_sh     <= 1'b0;
      dp_sh       <= '0;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      an          <= '1;
      frame_tick  <= 1'b0;
    end else begin
      if (load) begin
        val_sh  <= value;
        mode_sh <= mode;
        dp_sh   <= dp_in;
      end
      presc <= presc_wrap ? '0 : presc + PW'(1);
      if (presc_wrap)
        idx <= idx_wrap ? '0 : idx + IW'(1);
      frame_tick <= frame_wrap;
      if (frame_wrap) begin
        if (blink_wrap) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
      seg <= seg_d;
      dp  <= dp_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized bench for seven_seg_scan_driver against a
// cycle-count based reference model.
module tb_seven_seg_scan_driver;

  localparam int D  = 4;
  localparam int SD = 4;
  localparam int GD = 1;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [15:0]   value;
  logic          mode;
  logic [3:0]    dp_in;
  logic          blank_lz;
  logic [3:0]    blink_mask;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_tick;

  seven_seg_scan_driver #(
    .DIGITS(D), .SCAN_DIV(SD),
    .GUARD(GD), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .value(value), .mode(mode), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_mask(blink_mask),
    .seg(seg), .dp(dp), .an(an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // model state: edges since reset release and the latched load
  int          cnt;
  logic [15:0] m_val;
  logic        m_mode;
  logic [3:0]  m_dp;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cnt=%0d got=%h want=%h",
               tag, cnt, obs, exp);
    end
  endtask

  function automatic int nib(input int i);
    nib = int'((m_val >> (4 * i)) & 16'hF);
  endfunction

  function automatic bit zero_code(input int n);
    zero_code = m_mode ? (n == 1) : (n == 0);
  endfunction

  task automatic step();
    int   presc, slot, idx, frames, phase, top, n, s;
    bit   blank, seg_chk;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_tick;
    @(posedge clk);
    seg_chk = 1'b1;
    if (!rst_n) begin
      e_an = 4'hF; e_seg = 7'h7F;
      e_dp = 1'b1; e_tick = 1'b0;
      cnt = 0; m_val = '0; m_mode = 1'b0; m_dp = '0;
    end else begin
      presc  = cnt % SD;
      slot   = cnt / SD;
      idx    = slot % D;
      frames = slot / D;
      phase  = (frames / BF) % 2;
      e_tick = ((cnt % (SD * D)) == SD * D - 1);
      top = 0;
      for (int i = 0; i < D; i++)
        if (!zero_code(nib(i))) top = i;
      blank = (blank_lz && idx > top) ||
              (phase == 1 && blink_mask[idx]);
      n = nib(idx);
      if (!m_mode)        s = n;
      else if (n == 0)    s = 15;
      else if (n <= 10)   s = n - 1;
      else                s = n;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (!blank) begin
        e_seg = glyph_tab[s];
        e_dp  = ~m_dp[idx];
        if (presc >= GD) e_an = ~(4'b1 << idx);
      end
      seg_chk = !(presc < GD);
      if (load) begin
        m_val = value; m_mode = mode; m_dp = dp_in;
      end
      cnt++;
    end
    #1;
    chk("an", 32'(an), 32'(e_an));
    chk("frame_tick", 32'(frame_tick), 32'(e_tick));
    if (seg_chk) begin
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dp", 32'(dp), 32'(e_dp));
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(
    input logic [15:0] v,
    input logic        m,
    input logic [3:0]  d
  );
    load = 1'b1; value = v; mode = m; dp_in = d;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; mode = 1'b0;
    dp_in = '0; blank_lz = 1'b0; blink_mask = '0;
    cnt = 0; m_val = '0; m_mode = 1'b0; m_dp = '0;
    run(3);
    rst_n = 1'b1;
    run(22);
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(40);
    do_load(16'h1234, 1'b0, 4'b0000);
    run(40);
    do_load(16'hFA10, 1'b1, 4'b0101);
    run(40);
    blank_lz = 1'b1;
    do_load(16'h0050, 1'b0, 4'b0010);
    run(24);
    do_load(16'h0000, 1'b0, 4'b0000);
    run(24);
    do_load(16'h1131, 1'b1, 4'b0000);
    run(24);
    blank_lz = 1'b0;
    do_load(16'h1234, 1'b0, 4'b1000);
    blink_mask = 4'b0001;
    run(120);
    blink_mask = 4'b0000;
    // mid-slot load while digit 0 is being shown
    while (!(((cnt / SD) % D) == 0 && (cnt % SD) == 2)) step();
    do_load(16'h0009, 1'b0, 4'b0000);
    run(8);
    for (int k = 0; k < 1500; k++) begin
      load  = ($urandom_range(0, 5) == 0);
      value = 16'($urandom);
      mode  = 1'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(0, 39) == 0)
        blank_lz = ~blank_lz;
      if ($urandom_range(0, 59) == 0)
        blink_mask = 4'($urandom);
      if ($urandom_range(0, 3) == 0)
        value[15:8] = 8'h00;
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    load  = 1'b0;
    run(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
